// File: rtl/matmul_feeder.sv
// Host-side feeder/collector for the 4x4 systolic matmul core: skews A/B into wavefronts and gathers C rows.
// Optional drain watchdog: define MATMUL_FEED_TIMEOUT_EN.

module matmul_feeder_lane #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int LANE   = 0
)(
  input  logic [CNT_W-1:0]    i_step,
  input  logic [N*DATA_W-1:0] i_a_row,
  input  logic [N*DATA_W-1:0] i_b_col,
  output logic [DATA_W-1:0]   o_a,
  output logic [DATA_W-1:0]   o_b
);
  // k = step-1-LANE; row/column vectors are pre-arranged so element k sits at slice k
  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(i_step) == k + 1 + LANE) begin
        o_a = i_a_row[k*DATA_W +: DATA_W];
        o_b = i_b_col[k*DATA_W +: DATA_W];
      end
    end
  end
endmodule

module matmul_feeder #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ld_valid,
  output logic                    o_ld_ready,
  input  logic [N*N*DATA_W-1:0]   i_ld_a_flat,
  input  logic [N*N*DATA_W-1:0]   i_ld_b_flat,
  output logic                    o_input_start,
  output logic [CNT_W-1:0]        o_counter,
  output logic [N*DATA_W-1:0]     o_inA_flat,
  output logic [N*DATA_W-1:0]     o_inB_flat,
  input  logic                    i_output_rdy,
  input  logic [N*DATA_W-1:0]     i_outD_flat,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [N*N*DATA_W-1:0]   o_res_c_flat,
  output logic                    o_err
);
  localparam int IW = $clog2(N+1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_FEED, ST_DRAIN, ST_DONE} state_t;

  state_t                  r_state, w_nxt_state;
  logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
  logic                    r_ld_ready, r_start, r_res_valid, r_ph;
  logic [N*DATA_W-1:0]     r_in_a, r_in_b, w_lane_a, w_lane_b;
  logic [N*N*DATA_W-1:0]   r_a, r_b, r_res;
  logic [IW-1:0]           r_idx;
  logic                    w_load, w_cap, w_capst;

  assign o_ld_ready    = r_ld_ready;
  assign o_input_start = r_start;
  assign o_counter     = r_cnt;
  assign o_inA_flat    = r_in_a;
  assign o_inB_flat    = r_in_b;
  assign o_res_valid   = r_res_valid;
  assign o_res_c_flat  = r_res;

  // Lane g takes row g of A and column g of B, both arranged so step k lands at slice k
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N*DATA_W-1:0] w_b_col;
    for (genvar r = 0; r < N; r++) begin : g_bc
      assign w_b_col[(N-1-r)*DATA_W +: DATA_W] = r_b[(N*N-1-(r*N+g))*DATA_W +: DATA_W];
    end
    matmul_feeder_lane #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W), .LANE(g)) u_lane (
      .i_step  (w_nxt_cnt),
      .i_a_row (r_a[(N-1-g)*N*DATA_W +: N*DATA_W]),
      .i_b_col (w_b_col),
      .o_a     (w_lane_a[(N-1-g)*DATA_W +: DATA_W]),
      .o_b     (w_lane_b[(N-1-g)*DATA_W +: DATA_W])
    );
  end

  assign w_capst = (r_state == ST_START) || (r_state == ST_FEED) || (r_state == ST_DRAIN);

`ifdef MATMUL_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_tmo;
  logic          r_err, w_tmo_hit;
  assign o_err = r_err;
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT);
  assign o_err = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_load      = 1'b0;
    w_cap       = 1'b0;
`ifdef MATMUL_FEED_TIMEOUT_EN
    w_tmo_hit   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_ld_valid && r_ld_ready) begin
          w_load      = 1'b1;
          w_nxt_state = ST_START;
          w_nxt_cnt   = '0;
        end
      end
      ST_START: begin
        w_nxt_cnt = '0;
        if (r_ph) begin
          w_nxt_state = ST_FEED;
          w_nxt_cnt   = CNT_W'(1);
        end
      end
      ST_FEED: begin
        w_nxt_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(2*N-1)) w_nxt_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_nxt_cnt = r_cnt + CNT_W'(1);
`ifdef MATMUL_FEED_TIMEOUT_EN
        if (r_tmo == TW'(TIMEOUT-1)) begin
          w_tmo_hit   = 1'b1;
          w_nxt_state = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (i_res_ready) w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    // A row landing on the final drain cycle wins over the watchdog
    if (w_capst && i_output_rdy && (r_idx < IW'(N))) begin
      w_cap = 1'b1;
      if (r_idx == IW'(N-1)) begin
        w_nxt_state = ST_DONE;
`ifdef MATMUL_FEED_TIMEOUT_EN
        w_tmo_hit   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ld_ready  <= 1'b0;
      r_start     <= 1'b0;
      r_cnt       <= '0;
      r_ph        <= 1'b0;
      r_in_a      <= '0;
      r_in_b      <= '0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ld_ready  <= (w_nxt_state == ST_IDLE);
      r_start     <= (w_nxt_state == ST_START);
      r_cnt       <= w_nxt_cnt;
      r_ph        <= (r_state == ST_START) && !r_ph;
      r_in_a      <= (w_nxt_state == ST_FEED) ? w_lane_a : '0;
      r_in_b      <= (w_nxt_state == ST_FEED) ? w_lane_b : '0;
      r_res_valid <= (w_nxt_state == ST_DONE);
      if (w_load) begin
        r_a   <= i_ld_a_flat;
        r_b   <= i_ld_b_flat;
        r_idx <= '0;
        r_res <= '0;
      end else if (w_cap) begin
        r_res[(N-1-int'(r_idx))*N*DATA_W +: N*DATA_W] <= i_outD_flat;
        r_idx <= r_idx + IW'(1);
      end
    end
  end

`ifdef MATMUL_FEED_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == ST_DRAIN && w_nxt_state == ST_DRAIN) ? r_tmo + TW'(1) : '0;
      r_err <= r_err | w_tmo_hit;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: a stub core checks the wavefront and returns rows of A*B.
module tb_matmul_feeder;
  localparam int N = 4, DW = 32, CW = 4, LW = N*DW, NN = N*N*DW;

  logic          clk = 1'b0;
  logic          rst, ld_valid, ld_ready, input_start, output_rdy, res_valid, res_ready, err;
  logic [NN-1:0] ld_a, ld_b, res_c;
  logic [CW-1:0] counter;
  logic [LW-1:0] inA, inB, outD;
  logic          stub_rdy, extra_rdy;
  logic [LW-1:0] stub_d, extra_d;

  always #5 clk = ~clk;
  assign output_rdy = stub_rdy | extra_rdy;
  assign outD       = extra_rdy ? extra_d : stub_d;

  matmul_feeder #(.N(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_a_flat(ld_a), .i_ld_b_flat(ld_b), .o_input_start(input_start),
    .o_counter(counter), .o_inA_flat(inA), .o_inB_flat(inB),
    .i_output_rdy(output_rdy), .i_outD_flat(outD), .o_res_valid(res_valid),
    .i_res_ready(res_ready), .o_res_c_flat(res_c), .o_err(err));

  int            n_chk = 0, n_fail = 0;
  logic [NN-1:0] exp_q[$];
  logic [NN-1:0] cur_a, cur_b, stub_c, last_res;
  int            stub_rows, rv_rises, ist_cnt;
  logic [LW-1:0] rec_a [2*N], rec_b [2*N];

  task automatic chk(input string tag, input logic [NN-1:0] got, input logic [NN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(input logic [NN-1:0] m, input int r, input int c);
    return m[(N*N-1-(r*N+c))*DW +: DW];
  endfunction

  function automatic logic [NN-1:0] mmul(input logic [NN-1:0] a, input logic [NN-1:0] b);
    logic [NN-1:0] c;
    logic [DW-1:0] acc;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) acc += el(a, r, k) * el(b, k, j);
        c[(N*N-1-(r*N+j))*DW +: DW] = acc;
      end
    return c;
  endfunction

  // Expected wavefront at step s straight from the skew rule
  function automatic logic [LW-1:0] lanes(input logic [NN-1:0] m, input int s, input bit is_b);
    logic [LW-1:0] v;
    int k;
    v = '0;
    for (int i = 0; i < N; i++) begin
      k = s - 1 - i;
      if (k >= 0 && k < N) v[(N-1-i)*DW +: DW] = is_b ? el(m, N-1-k, i) : el(m, i, N-1-k);
    end
    return v;
  endfunction

  function automatic logic [NN-1:0] rnd_mat();
    logic [NN-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  // Stub core: checks each wavefront step, then returns rows of the product every other cycle
  initial begin : stub
    bit feeding, pend, prev_rv;
    int gap, emit, s;
    feeding = 0; pend = 0; prev_rv = 0; gap = 0; emit = 0;
    stub_rdy = 1'b0; stub_d = '0;
    forever begin
      @(posedge clk); #1;
      stub_rdy = 1'b0;
      if (res_valid && !prev_rv) rv_rises++;
      prev_rv = res_valid;
      if (rst) begin
        feeding = 0; pend = 0;
      end else begin
        if (input_start) begin
          feeding = 1; ist_cnt++;
          chk("start_lanes", {inA, inB}, '0);
        end
        s = int'(counter);
        if (feeding && s >= 1 && s <= 2*N-1) begin
          rec_a[s] = inA; rec_b[s] = inB;
          chk($sformatf("lane_a_s%0d", s), inA, lanes(cur_a, s, 0));
          chk($sformatf("lane_b_s%0d", s), inB, lanes(cur_b, s, 1));
          if (s == 2*N-1) begin feeding = 0; pend = 1; gap = 2; emit = 0; end
        end else if (pend) begin
          if (gap > 0) gap--;
          else if (emit < stub_rows) begin
            stub_rdy = 1'b1;
            stub_d   = stub_c[(N-1-emit)*LW +: LW];
            emit++; gap = 1;
          end else pend = 0;
        end
      end
    end
  end

  task automatic load(input logic [NN-1:0] a, input logic [NN-1:0] b);
    int t;
    @(negedge clk);
    ld_a = a; ld_b = b; ld_valid = 1'b1;
    cur_a = a; cur_b = b; stub_c = mmul(a, b); rv_rises = 0; ist_cnt = 0;
    t = 0;
    while (!ld_ready && t < 100) begin @(negedge clk); t++; end
    if (!ld_ready) chk("ld_ready_timeout", 0, 1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    exp_q.push_back(stub_c);
    chk("ld_ready_drop", ld_ready, 0);
  endtask

  task automatic get_result(input int hold);
    int t;
    logic [NN-1:0] snap, exp;
    logic [CW-1:0] cs;
    bit bad;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 400) begin @(negedge clk); t++; end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!res_valid) begin chk("res_valid_timeout", 0, 1); return; end
    snap = res_c; cs = counter; bad = 0;
    if (hold > 0) begin
      ld_valid = 1'b1; ld_a = ~snap; ld_b = snap;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!res_valid || res_c !== snap || ld_ready || input_start) bad = 1;
        extra_rdy = (i == 3);
        extra_d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      extra_rdy = 1'b0; ld_valid = 1'b0;
      chk("hold_stable", bad, 0);
      chk("hold_res_unchanged", res_c, snap);
      chk("hold_lanes_zero", {inA, inB}, '0);
      chk("hold_counter_frozen", counter, cs);
    end
    chk("res_c", res_c, exp);
    last_res = res_c;
    res_ready = 1'b1;
    chk("hs_ld_ready_low", ld_ready, 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("hs_res_valid_drop", res_valid, 0);
    chk("hs_ld_ready_up", ld_ready, 1);
  endtask

  initial begin : main
    logic [NN-1:0] a1, b1, id, m;
    int t;
    rst = 1'b1; ld_valid = 1'b0; res_ready = 1'b0; extra_rdy = 1'b0; extra_d = '0;
    ld_a = '0; ld_b = '0; stub_rows = N; cur_a = '0; cur_b = '0; stub_c = '0;
    for (int i = 0; i < N*N; i++) a1[(N*N-1-i)*DW +: DW] = DW'(i + 1);
    b1 = {32'd2, 32'd7, 32'd9, 32'd0,  32'd0, 32'd2, 32'd0, 32'd82,
          32'd4, 32'd0, 32'd2, 32'd0,  32'd0, 32'd0, 32'd0, 32'd1};
    id = '0;
    for (int i = 0; i < N; i++) id[(N*N-1-(i*N+i))*DW +: DW] = DW'(1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_start", input_start, 0);
    chk("rst_counter", counter, 0);
    chk("rst_lanes", {inA, inB}, '0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_c", res_c, '0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ld_ready", ld_ready, 1);

    // Worked example plus skew spot checks
    load(a1, b1);
    get_result(0);
    chk("t1_row0", last_res[3*LW +: LW], {32'd14, 32'd11, 32'd15, 32'd168});
    chk("t1_row1", last_res[2*LW +: LW], {32'd38, 32'd47, 32'd59, 32'd500});
    chk("t1_res_valid_rises", rv_rises, 1);
    chk("t2_start_cycles", ist_cnt, 2);
    chk("t2_a_s1", rec_a[1], {32'd4, 32'd0, 32'd0, 32'd0});
    chk("t2_b_s1", rec_b[1], '0);
    chk("t2_a_s4", rec_a[4], {32'd1, 32'd6, 32'd11, 32'd16});
    chk("t2_b_s4", rec_b[4], {32'd2, 32'd2, 32'd2, 32'd1});
    chk("t2_a_s7", rec_a[7], {32'd0, 32'd0, 32'd0, 32'd13});
    chk("t2_b_s7", rec_b[7], '0);

    // Identity B returns A unchanged
    load(a1, id);
    get_result(0);
    chk("t3_c_eq_a", last_res, a1);

    // Result held in DONE with stray rows and a pending load
    load(rnd_mat(), rnd_mat());
    get_result(10);

    // Reset mid-feed, then a fresh load
    load(a1, b1);
    t = 0;
    @(negedge clk);
    while (counter != CW'(3) && t < 50) begin @(negedge clk); t++; end
    if (counter != CW'(3)) chk("t5_counter3_timeout", counter, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_ld_ready", ld_ready, 0);
    chk("t5_start", input_start, 0);
    chk("t5_counter", counter, 0);
    chk("t5_lanes", {inA, inB}, '0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_c", res_c, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("t5_ld_ready_back", ld_ready, 1);
    load(b1, a1);
    get_result(0);

    for (int r = 0; r < 2; r++) begin
      load(rnd_mat(), rnd_mat());
      get_result(0);
    end

`ifdef MATMUL_FEED_TIMEOUT_EN
    stub_rows = 2;
    load(a1, b1);
    m = exp_q.pop_back();
    m[2*LW-1:0] = '0;
    exp_q.push_back(m);
    get_result(0);
    chk("t6_err", err, 1);
    stub_rows = N;
`else
    m = '0;
    chk("err_tied_low", err | (m != '0), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
